// File: rtl/vx_result_assembler_if.sv
// vx_result_assembler_if
// Bundles the result-packet input stream, the assembled-warp output stream and
// the sticky framing-error flag of vx_result_assembler.
//   in_*      : NUM_LANES-wide packet stream (valid/ready, meta, tmask, data, pid, sop, eop)
//   out_*     : NUM_THREADS-wide warp stream (valid/ready, meta, tmask, data)
//   proto_err : sticky framing-error indication
// modport master : producer of packets / consumer of warps (execute side + commit side)
// modport slave  : the assembler itself
interface vx_result_assembler_if #(
  parameter int NUM_LANES   = 4,
  parameter int NUM_THREADS = 16,
  parameter int META_W      = 64,
  parameter int DATA_W      = 32
);
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
  localparam int PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;

  logic                          in_valid;
  logic                          in_ready;
  logic [META_W-1:0]             in_meta;
  logic [NUM_LANES-1:0]          in_tmask;
  logic [NUM_LANES*DATA_W-1:0]   in_data;
  logic [PID_WIDTH-1:0]          in_pid;
  logic                          in_sop;
  logic                          in_eop;

  logic                          out_valid;
  logic                          out_ready;
  logic [META_W-1:0]             out_meta;
  logic [NUM_THREADS-1:0]        out_tmask;
  logic [NUM_THREADS*DATA_W-1:0] out_data;

  logic                          proto_err;

  modport master (
    output in_valid, in_meta, in_tmask, in_data, in_pid, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_meta, out_tmask, out_data, proto_err
  );

  modport slave (
    input  in_valid, in_meta, in_tmask, in_data, in_pid, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_meta, out_tmask, out_data, proto_err
  );
endinterface

// File: rtl/vx_result_assembler.sv
// vx_result_assembler
// Reassembles NUM_LANES-wide, pid/sop/eop framed result packets coming out of a
// narrow execute unit into one NUM_THREADS-wide warp result for commit.
// Packet lane j with pid p lands on thread p*NUM_LANES + j; threads of packets
// never received, and inactive lanes of received packets, read back as zero.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high; discards any partial warp
//   io    : vx_result_assembler_if.slave (packet in, warp out, proto_err)
// Storage: an accumulator bank (acc_*) collects packets of the current
// instruction; an output bank (out_*) holds the finished warp until it is
// accepted. A single-packet instruction bypasses the accumulator.
module vx_result_assembler #(
  parameter int NUM_LANES   = 4,
  parameter int NUM_THREADS = 16,
  parameter int META_W      = 64,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_result_assembler_if.slave   io
);

  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
  localparam int PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;

  if ((NUM_THREADS % NUM_LANES) != 0) begin : g_bad_cfg
    $error("vx_result_assembler: NUM_THREADS must be a multiple of NUM_LANES");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  state_e                        state_q,     state_d;
  logic [NUM_THREADS-1:0]        acc_tmask_q, acc_tmask_d;
  logic [NUM_THREADS*DATA_W-1:0] acc_data_q,  acc_data_d;
  logic [PID_WIDTH-1:0]          last_pid_q,  last_pid_d;
  logic                          out_valid_q, out_valid_d;
  logic [META_W-1:0]             out_meta_q,  out_meta_d;
  logic [NUM_THREADS-1:0]        out_tmask_q, out_tmask_d;
  logic [NUM_THREADS*DATA_W-1:0] out_data_q,  out_data_d;
  logic                          proto_err_q, proto_err_d;

  logic                          in_fire;
  logic                          start_new;
  logic                          frame_err;
  logic [NUM_THREADS-1:0]        mrg_tmask;
  logic [NUM_THREADS*DATA_W-1:0] mrg_data;

  // An eop packet completes a warp, so it can only be taken when the output
  // bank is free or being drained this cycle; other packets never stall.
  assign io.in_ready = !io.in_eop || !out_valid_q || io.out_ready;
  assign in_fire     = io.in_valid && io.in_ready;

  // Any packet seen in IDLE, or any sop, begins a fresh instruction, so the
  // stale accumulator contents must not leak into the merge.
  assign start_new = (state_q == IDLE) || io.in_sop;

  // Merge the incoming packet into its slot on top of the accumulator (or on
  // top of an empty warp when starting a new instruction).
  always_comb begin
    mrg_tmask = start_new ? '0 : acc_tmask_q;
    mrg_data  = start_new ? '0 : acc_data_q;
    for (int p = 0; p < NUM_PACKETS; p++) begin
      if (io.in_pid == PID_WIDTH'(p)) begin
        mrg_tmask[p*NUM_LANES +: NUM_LANES] = io.in_tmask;
        for (int j = 0; j < NUM_LANES; j++) begin
          mrg_data[(p*NUM_LANES+j)*DATA_W +: DATA_W] =
            io.in_tmask[j] ? io.in_data[j*DATA_W +: DATA_W] : '0;
        end
      end
    end
  end

  // Next-state and output-bank control.
  always_comb begin
    state_d     = state_q;
    acc_tmask_d = acc_tmask_q;
    acc_data_d  = acc_data_q;
    last_pid_d  = last_pid_q;
    out_valid_d = out_valid_q;
    out_meta_d  = out_meta_q;
    out_tmask_d = out_tmask_q;
    out_data_d  = out_data_q;
    proto_err_d = proto_err_q;
    frame_err   = 1'b0;

    if (out_valid_q && io.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      last_pid_d = io.in_pid;

      // Framing checks: sop mid-instruction, missing sop, or pids that do not
      // strictly increase. The packet is still merged in every case.
      if (state_q == COLLECT) begin
        frame_err = io.in_sop || (io.in_pid <= last_pid_q);
      end else begin
        frame_err = !io.in_sop;
      end

      if (io.in_eop) begin
        // A warp with no active thread has nothing to commit; only the
        // framing is closed.
        if (|mrg_tmask) begin
          out_valid_d = 1'b1;
          out_meta_d  = io.in_meta;
          out_tmask_d = mrg_tmask;
          out_data_d  = mrg_data;
        end
        acc_tmask_d = '0;
        acc_data_d  = '0;
        state_d     = IDLE;
      end else begin
        acc_tmask_d = mrg_tmask;
        acc_data_d  = mrg_data;
        state_d     = COLLECT;
      end
    end

    if (frame_err) begin
      proto_err_d = 1'b1;
    end
  end

  // Register stage: accumulator, output bank and control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_tmask_q <= '0;
      acc_data_q  <= '0;
      last_pid_q  <= '0;
      out_valid_q <= 1'b0;
      out_meta_q  <= '0;
      out_tmask_q <= '0;
      out_data_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_tmask_q <= acc_tmask_d;
      acc_data_q  <= acc_data_d;
      last_pid_q  <= last_pid_d;
      out_valid_q <= out_valid_d;
      out_meta_q  <= out_meta_d;
      out_tmask_q <= out_tmask_d;
      out_data_q  <= out_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_meta  = out_meta_q;
  assign io.out_tmask = out_tmask_q;
  assign io.out_data  = out_data_q;
  assign io.proto_err = proto_err_q;

endmodule

// File: tb/tb_vx_result_assembler.sv
// Testbench for vx_result_assembler: a 4-lane/16-thread instance (u_a) and a
// 4-lane/4-thread instance (u_b). Drivers push expected warps into per-DUT
// queues when the eop packet is accepted; monitors pop and compare on every
// output handshake.
module tb_vx_result_assembler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vx_result_assembler_if #(.NUM_LANES(4), .NUM_THREADS(16), .META_W(64), .DATA_W(32)) ifa ();
  vx_result_assembler_if #(.NUM_LANES(4), .NUM_THREADS(4),  .META_W(64), .DATA_W(32)) ifb ();

  vx_result_assembler #(.NUM_LANES(4), .NUM_THREADS(16), .META_W(64), .DATA_W(32)) u_a (
    .clk   (clk),
    .reset (reset),
    .io    (ifa)
  );

  vx_result_assembler #(.NUM_LANES(4), .NUM_THREADS(4), .META_W(64), .DATA_W(32)) u_b (
    .clk   (clk),
    .reset (reset),
    .io    (ifb)
  );

  typedef struct packed {
    logic [15:0]  tm;
    logic [511:0] d;
    logic [63:0]  m;
  } exp_a_t;

  typedef struct packed {
    logic [3:0]   tm;
    logic [127:0] d;
    logic [63:0]  m;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];

  bit           seen_b;
  logic [511:0] e1, e2, ea3, eb3, e5, e6;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] put(input logic [511:0] v, input int k, input logic [31:0] x);
    logic [511:0] r;
    r = v;
    r[k*32 +: 32] = x;
    return r;
  endfunction

  // lane0 in the low bits
  function automatic logic [127:0] l4(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic send_a(input logic [1:0] pid, input logic sop, input logic eop,
                        input logic [3:0] tm, input logic [127:0] d, input logic [63:0] meta,
                        input bit push, input logic [15:0] etm, input logic [511:0] edat);
    bit     ok;
    exp_a_t e;
    ok           = 1'b0;
    ifa.in_valid = 1'b1;
    ifa.in_pid   = pid;
    ifa.in_sop   = sop;
    ifa.in_eop   = eop;
    ifa.in_tmask = tm;
    ifa.in_data  = d;
    ifa.in_meta  = meta;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ifa.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_a_ready: in_ready stayed 0 for pid %0d, required 1", pid);
    end else if (eop && push) begin
      e.tm = etm;
      e.d  = edat;
      e.m  = meta;
      qa.push_back(e);
    end
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] tm, input logic [127:0] d, input logic [63:0] meta,
                        input logic [127:0] edat);
    bit     ok;
    exp_b_t e;
    ok           = 1'b0;
    ifb.in_valid = 1'b1;
    ifb.in_pid   = 1'b0;
    ifb.in_sop   = 1'b1;
    ifb.in_eop   = 1'b1;
    ifb.in_tmask = tm;
    ifb.in_data  = d;
    ifb.in_meta  = meta;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ifb.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_b_ready: in_ready stayed 0, required 1");
    end else begin
      e.tm = tm;
      e.d  = edat;
      e.m  = meta;
      qb.push_back(e);
    end
    @(posedge clk);
    #1;
    ifb.in_valid = 1'b0;
  endtask

  task automatic mon_a();
    exp_a_t e;
    forever begin
      @(negedge clk);
      if (!reset && ifa.out_valid && ifa.out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_a_unexpected: got warp tmask %0h, required none", ifa.out_tmask);
        end else begin
          e = qa.pop_front();
          chk("a_tmask", ifa.out_tmask, e.tm);
          chk("a_data",  ifa.out_data,  e.d);
          chk("a_meta",  ifa.out_meta,  e.m);
        end
      end
    end
  endtask

  task automatic mon_b();
    exp_b_t e;
    forever begin
      @(negedge clk);
      if (!reset && ifb.out_valid && ifb.out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_b_unexpected: got warp tmask %0h, required none", ifb.out_tmask);
        end else begin
          e = qb.pop_front();
          chk("b_tmask", ifb.out_tmask, e.tm);
          chk("b_data",  ifb.out_data,  e.d);
          chk("b_meta",  ifb.out_meta,  e.m);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    ifa.in_valid  = 1'b0;
    ifa.in_meta   = '0;
    ifa.in_tmask  = '0;
    ifa.in_data   = '0;
    ifa.in_pid    = '0;
    ifa.in_sop    = 1'b0;
    ifa.in_eop    = 1'b0;
    ifa.out_ready = 1'b1;
    ifb.in_valid  = 1'b0;
    ifb.in_meta   = '0;
    ifb.in_tmask  = '0;
    ifb.in_data   = '0;
    ifb.in_pid    = '0;
    ifb.in_sop    = 1'b0;
    ifb.in_eop    = 1'b0;
    ifb.out_ready = 1'b1;
    seen_b        = 1'b0;

    fork
      mon_a();
      mon_b();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid_a", ifa.out_valid, 1'b0);
    chk("rst_proto_err_a", ifa.proto_err, 1'b0);
    chk("rst_out_tmask_a", ifa.out_tmask, 16'h0);
    chk("rst_out_data_a",  ifa.out_data,  512'h0);
    chk("rst_out_valid_b", ifb.out_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: full warp, data = thread id
    e1 = '0;
    for (int k = 0; k < 16; k++) e1 = put(e1, k, k);
    for (int p = 0; p < 3; p++) begin
      send_a(2'(p), (p == 0), 1'b0, 4'hF, l4(4*p, 4*p+1, 4*p+2, 4*p+3), 64'h1, 1'b0, '0, '0);
    end
    chk("t1_no_early_valid", ifa.out_valid, 1'b0);
    send_a(2'd3, 1'b0, 1'b1, 4'hF, l4(12, 13, 14, 15), 64'h1111, 1'b1, 16'hFFFF, e1);
    chk("t1_latency_valid", ifa.out_valid, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Test 2: sparse warp, inactive lanes carry garbage that must read back as 0
    e2 = put(put(put(512'h0, 4, 32'h44), 5, 32'h55), 15, 32'hFF);
    send_a(2'd1, 1'b1, 1'b0, 4'h3, l4(32'h44, 32'h55, 32'hEE, 32'hEE), 64'h2, 1'b0, '0, '0);
    send_a(2'd3, 1'b0, 1'b1, 4'h8, l4(32'hEE, 32'hEE, 32'hEE, 32'hFF), 64'h2222, 1'b1,
           16'h8030, e2);
    repeat (2) @(posedge clk);
    #1;

    // Test 4: single-packet warps back to back on the 4-thread instance
    fork
      begin
        send_b(4'hF, l4(0, 1, 2, 3),     64'd0, l4(0, 1, 2, 3));
        send_b(4'h5, l4(16, 17, 18, 19), 64'd1, l4(16, 0, 18, 0));
        send_b(4'hA, l4(32, 33, 34, 35), 64'd2, l4(0, 33, 0, 35));
        send_b(4'h3, l4(48, 49, 50, 51), 64'd3, l4(48, 49, 0, 0));
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (ifb.out_valid) begin
            seen_b = 1'b1;
            break;
          end
        end
        chk("t4_first_valid", seen_b, 1'b1);
        repeat (3) begin
          @(negedge clk);
          chk("t4_no_bubble", ifb.out_valid, 1'b1);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Test 3: warp A held, warp B body flows, B eop stalls until A drains
    ea3 = '0;
    eb3 = '0;
    for (int k = 0; k < 16; k++) begin
      ea3 = put(ea3, k, 32'h300 + k);
      eb3 = put(eb3, k, 32'h400 + k);
    end
    ifa.out_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      send_a(2'(p), (p == 0), (p == 3), 4'hF,
             l4(32'h300 + 4*p, 32'h301 + 4*p, 32'h302 + 4*p, 32'h303 + 4*p),
             64'h3A, 1'b1, 16'hFFFF, ea3);
    end
    chk("t3_a_valid", ifa.out_valid, 1'b1);
    for (int p = 0; p < 3; p++) begin
      send_a(2'(p), (p == 0), 1'b0, 4'hF,
             l4(32'h400 + 4*p, 32'h401 + 4*p, 32'h402 + 4*p, 32'h403 + 4*p),
             64'h0, 1'b0, '0, '0);
    end
    fork
      send_a(2'd3, 1'b0, 1'b1, 4'hF, l4(32'h40C, 32'h40D, 32'h40E, 32'h40F),
             64'h3B, 1'b1, 16'hFFFF, eb3);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t3_eop_stall", ifa.in_ready, 1'b0);
          chk("t3_a_stable", ifa.out_data, ea3);
        end
        @(posedge clk);
        #1;
        ifa.out_ready = 1'b1;
      end
    join
    chk("t3_b_valid", ifa.out_valid, 1'b1);
    chk("t3_b_data",  ifa.out_data,  eb3);
    repeat (2) @(posedge clk);
    #1;

    // Test 5: second sop before eop discards the first partial warp
    chk("t5_perr_clear", ifa.proto_err, 1'b0);
    send_a(2'd0, 1'b1, 1'b0, 4'hF, l4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 64'h0, 1'b0, '0, '0);
    send_a(2'd1, 1'b0, 1'b0, 4'hF, l4(32'hB0, 32'hB1, 32'hB2, 32'hB3), 64'h0, 1'b0, '0, '0);
    chk("t5_perr_before", ifa.proto_err, 1'b0);
    send_a(2'd0, 1'b1, 1'b0, 4'h1, l4(32'h50, 32'hEE, 32'hEE, 32'hEE), 64'h0, 1'b0, '0, '0);
    chk("t5_perr_set", ifa.proto_err, 1'b1);
    e5 = put(put(512'h0, 0, 32'h50), 9, 32'h91);
    send_a(2'd2, 1'b0, 1'b1, 4'h2, l4(32'hEE, 32'h91, 32'hEE, 32'hEE), 64'h55, 1'b1,
           16'h0201, e5);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_perr_sticky", ifa.proto_err, 1'b1);

    // Test 6: reset in the middle of a collection with a result pending
    ifa.out_ready = 1'b0;
    send_a(2'd0, 1'b1, 1'b1, 4'hF, l4(1, 2, 3, 4), 64'h60, 1'b0, '0, '0);
    chk("t6_pending_valid", ifa.out_valid, 1'b1);
    send_a(2'd0, 1'b1, 1'b0, 4'hF, l4(5, 6, 7, 8), 64'h0, 1'b0, '0, '0);
    send_a(2'd1, 1'b0, 1'b0, 4'hF, l4(32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD), 64'h0,
           1'b0, '0, '0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", ifa.out_valid, 1'b0);
    chk("t6_rst_perr",  ifa.proto_err, 1'b0);
    chk("t6_rst_tmask", ifa.out_tmask, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    ifa.out_ready = 1'b1;
    e6 = '0;
    for (int k = 0; k < 4; k++) begin
      e6 = put(e6, k, 100 + k);
      e6 = put(e6, 8 + k, 108 + k);
    end
    send_a(2'd0, 1'b1, 1'b0, 4'hF, l4(100, 101, 102, 103), 64'h0, 1'b0, '0, '0);
    send_a(2'd2, 1'b0, 1'b1, 4'hF, l4(108, 109, 110, 111), 64'h66, 1'b1, 16'h0F0F, e6);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_perr_clean", ifa.proto_err, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
